i2c_slave: RTL

I2C target (responder) that answers a fixed 7-bit chip address on the same SDA/SCL pad style as the team's I2C master. It decodes START/STOP, acknowledges its address, and latches a register address of ADDR_BYTES bytes. It then performs byte writes or reads through a simple synchronous register-file port, auto-incrementing the address. No clock stretching; used as an on-chip peripheral and as the bus model for master regression.

---
 rtl/i2c_pkg.sv | 9 +
 rtl/i2c_slave_if.sv | 12 +
 rtl/i2c_bus_sync.sv | 34 +++
 rtl/i2c_slave.sv | 139 +++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: state encodings and bus constants shared by the I2C target and its synchroniser
package i2c_pkg;
  typedef enum logic [3:0] {
    s_idle, s_addr, s_addr_ack, s_reg_addr, s_reg_ack, s_write, s_write_ack, s_read, s_read_ack
  } state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/i2c_slave_if.sv
// i2c_slave_if: pad and register-file signals of the I2C target, named from the target's side
interface i2c_slave_if #(parameter int REG_ADDR_WIDTH = 8);
  logic i_sda, i_scl, o_sda, o_sda_oen;
  logic [6:0] i_chip_addr;
  logic [REG_ADDR_WIDTH-1:0] o_reg_addr;
  logic [7:0] o_wr_data, i_rd_data;
  logic o_wr_en, o_rd_en, o_busy;
  modport slave (input i_sda, i_scl, i_chip_addr, i_rd_data,
                 output o_sda, o_sda_oen, o_reg_addr, o_wr_data, o_wr_en, o_rd_en, o_busy);
  modport master (output i_sda, i_scl, i_chip_addr, i_rd_data,
                  input o_sda, o_sda_oen, o_reg_addr, o_wr_data, o_wr_en, o_rd_en, o_busy);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: SDA/SCL synchronisers with SCL edge and START/STOP condition pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sda,
  input  logic i_scl,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);
  import i2c_pkg::*;
  // top bit holds the previous synced sample for edge detection; reset to idle-high
  logic [SYNC_DEPTH:0] r_sda, r_scl;
  logic w_sda, w_sda_d, w_scl, w_scl_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_sda <= '1;
      r_scl <= '1;
    end else begin
      r_sda <= {r_sda[SYNC_DEPTH-1:0], i_sda};
      r_scl <= {r_scl[SYNC_DEPTH-1:0], i_scl};
    end
  assign w_sda = r_sda[SYNC_DEPTH-1];
  assign w_sda_d = r_sda[SYNC_DEPTH];
  assign w_scl = r_scl[SYNC_DEPTH-1];
  assign w_scl_d = r_scl[SYNC_DEPTH];
  assign o_sda = w_sda;
  assign o_scl_rise = w_scl & ~w_scl_d;
  assign o_scl_fall = ~w_scl & w_scl_d;
  assign o_start = w_scl & w_scl_d & w_sda_d & ~w_sda;
  assign o_stop = w_scl & w_scl_d & ~w_sda_d & w_sda;
endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: fixed-address I2C target with an auto-incrementing register-file port
module i2c_slave #(
  parameter int ADDR_BYTES = 1,
  parameter int REG_ADDR_WIDTH = 8 * ADDR_BYTES
) (
  input logic clk,
  input logic rst_n,
  i2c_slave_if.slave bus
);
  import i2c_pkg::*;
  localparam logic [1:0] NBYTES = 2'(ADDR_BYTES);
  localparam logic [1:0] LAST_BYTE = 2'(ADDR_BYTES - 1);
  state_t r_state, w_state;
  logic [7:0] r_shift, w_shift, r_wr_data, w_wr_data, w_byte;
  logic [2:0] r_bit_cnt, w_bit_cnt;
  logic [1:0] r_byte_cnt, w_byte_cnt;
  logic [REG_ADDR_WIDTH-1:0] r_acc, w_acc, w_acc_nxt, r_reg_addr, w_reg_addr;
  logic r_wr_en, w_wr_en, r_rd_en, w_rd_en, r_load, r_oen, w_oen, r_busy, w_busy, r_rw, w_rw;
  logic w_sda, w_rise, w_fall, w_start, w_stop, w_match;
  i2c_bus_sync u_sync (
    .clk, .rst_n, .i_sda(bus.i_sda), .i_scl(bus.i_scl), .o_sda(w_sda),
    .o_scl_rise(w_rise), .o_scl_fall(w_fall), .o_start(w_start), .o_stop(w_stop)
  );
  assign w_byte = {r_shift[6:0], w_sda};
  assign w_match = w_byte[7:1] == bus.i_chip_addr;
  assign w_acc_nxt = (r_acc << 8) | REG_ADDR_WIDTH'(w_byte);
  // in ACK states r_oen doubles as the phase: released means the ACK has not started yet
  always_comb begin
    w_state = r_state;
    w_shift = r_load ? bus.i_rd_data : r_shift;
    w_bit_cnt = r_bit_cnt;
    w_byte_cnt = r_byte_cnt;
    w_acc = r_acc;
    w_reg_addr = r_wr_en ? r_reg_addr + 1'b1 : r_reg_addr;
    w_wr_data = r_wr_data;
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    w_oen = r_oen;
    w_busy = r_busy;
    w_rw = r_rw;
    if (w_start || w_stop) begin
      w_state = w_start ? s_addr : s_idle;
      w_bit_cnt = '0;
      w_byte_cnt = '0;
      w_oen = 1'b1;
      w_busy = 1'b0;
    end else if (w_rise) begin
      case (r_state)
        s_addr, s_reg_addr, s_write: begin
          w_shift = w_byte;
          w_bit_cnt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == 3'd7) begin
            if (r_state == s_addr) begin
              w_busy = w_match;
              w_rw = w_byte[0];
              w_state = w_match ? s_addr_ack : s_idle;
            end else if (r_state == s_reg_addr) begin
              w_acc = w_acc_nxt;
              w_byte_cnt = r_byte_cnt + 1'b1;
              w_reg_addr = (r_byte_cnt == LAST_BYTE) ? w_acc_nxt : r_reg_addr;
              w_state = s_reg_ack;
            end else begin
              w_wr_data = w_byte;
              w_wr_en = 1'b1;
              w_state = s_write_ack;
            end
          end
        end
        s_read: begin
          w_bit_cnt = r_bit_cnt + 1'b1;
          w_state = (r_bit_cnt == 3'd7) ? s_read_ack : s_read;
        end
        s_read_ack: begin
          w_state = (w_sda == NACK) ? s_idle : s_read;
          w_busy = w_sda != NACK;
          w_rd_en = w_sda != NACK;
          w_reg_addr = (w_sda == NACK) ? r_reg_addr : r_reg_addr + 1'b1;
        end
        default: ;
      endcase
    end else if (w_fall) begin
      case (r_state)
        s_addr_ack, s_reg_ack, s_write_ack:
          if (r_oen) begin
            w_oen = ACK;
            w_rd_en = (r_state == s_addr_ack) && r_rw;
          end else begin
            w_state = (r_state == s_addr_ack) ? (r_rw ? s_read : s_reg_addr) :
                      (r_state == s_reg_ack && r_byte_cnt != NBYTES) ? s_reg_addr : s_write;
            w_oen = (w_state == s_read) ? r_shift[7] : 1'b1;
            w_shift = (w_state == s_read) ? {r_shift[6:0], 1'b1} : r_shift;
          end
        s_read: begin
          w_oen = r_shift[7];
          w_shift = {r_shift[6:0], 1'b1};
        end
        s_read_ack: w_oen = 1'b1;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= s_idle;
      r_shift <= '0;
      r_bit_cnt <= '0;
      r_byte_cnt <= '0;
      r_acc <= '0;
      r_reg_addr <= '0;
      r_wr_data <= '0;
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_load <= 1'b0;
      r_oen <= 1'b1;
      r_busy <= 1'b0;
      r_rw <= 1'b0;
    end else begin
      r_state <= w_state;
      r_shift <= w_shift;
      r_bit_cnt <= w_bit_cnt;
      r_byte_cnt <= w_byte_cnt;
      r_acc <= w_acc;
      r_reg_addr <= w_reg_addr;
      r_wr_data <= w_wr_data;
      r_wr_en <= w_wr_en;
      r_rd_en <= w_rd_en;
      r_load <= r_rd_en;
      r_oen <= w_oen;
      r_busy <= w_busy;
      r_rw <= w_rw;
    end
  assign bus.o_sda = 1'b0;
  assign bus.o_sda_oen = r_oen;
  assign bus.o_reg_addr = r_reg_addr;
  assign bus.o_wr_data = r_wr_data;
  assign bus.o_wr_en = r_wr_en;
  assign bus.o_rd_en = r_rd_en;
  assign bus.o_busy = r_busy;
endmodule
